// File: rtl/slave_ram_arb_pkg.sv
// Shared types and constants for the slave register RAM arbiter.
// No logic lives here. Every file that uses these names imports the package.
package slave_ram_arb_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_COMPLETE = 2'd2
    } state_e;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/slave_ram_arbiter.sv
// Purpose: shares the single 32x8 register RAM port between the I2C engine (A) and LCD/menu (B); optional A write-protect via SLAVE_RAM_ARB_WPROT_EN.
// Latency: request sampled on edge 0, gnt in cycle 1, rvalid in cycle 3; one access per 3 cycles.
// Backpressure: req is held until gnt; A has priority, but B wins after STARVE_MAX consecutive A grants while B is waiting.
module slave_ram_arbiter
    import slave_ram_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_rvalid,
`ifdef SLAVE_RAM_ARB_WPROT_EN
    input  logic [31:0]       wprot_mask,
    output logic              a_wprot_hit,
`endif
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_w,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [3:0] STARVE_LIM = STARVE_MAX[3:0];

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                op_we_q, op_we_d;
    logic [3:0]          starve_q, starve_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_din_q, ram_din_d;
    logic                ram_w_q, ram_w_d;
    logic                a_gnt_q, a_gnt_d;
    logic                b_gnt_q, b_gnt_d;
    logic                a_rvalid_q, a_rvalid_d;
    logic                b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;

    logic                pick_b;
    logic                grant_a;
    logic                grant_b;
    logic                a_blocked;

    // B wins contention only once A has used up its starvation allowance.
    assign pick_b  = b_req && (!a_req || (starve_q == STARVE_LIM));
    assign grant_b = (state_q == ST_IDLE) && pick_b;
    assign grant_a = (state_q == ST_IDLE) && a_req && !pick_b;

`ifdef SLAVE_RAM_ARB_WPROT_EN
    logic wprot_hit_q, wprot_hit_d;

    assign a_blocked   = wprot_mask[a_addr];
    assign a_wprot_hit = wprot_hit_q;

    always_comb begin
        wprot_hit_d = grant_a && a_we && a_blocked;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wprot_hit_q <= 1'b0;
        end else begin
            wprot_hit_q <= wprot_hit_d;
        end
    end
`else
    assign a_blocked = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        op_we_d    = op_we_q;
        starve_d   = starve_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_w_d    = 1'b0;
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_b || !b_req) begin
                    starve_d = '0;
                end else if (grant_a && (starve_q != STARVE_LIM)) begin
                    starve_d = starve_q + 4'd1;
                end

                if (grant_b) begin
                    state_d    = ST_ACCESS;
                    owner_d    = REQ_B;
                    op_we_d    = b_we;
                    ram_addr_d = b_addr;
                    ram_din_d  = b_wdata;
                    ram_w_d    = b_we;
                    b_gnt_d    = 1'b1;
                end else if (grant_a) begin
                    state_d    = ST_ACCESS;
                    owner_d    = REQ_A;
                    op_we_d    = a_we;
                    ram_addr_d = a_addr;
                    ram_din_d  = a_wdata;
                    ram_w_d    = a_we && !a_blocked;
                    a_gnt_d    = 1'b1;
                end
            end

            ST_ACCESS: begin
                state_d = ST_COMPLETE;
            end

            ST_COMPLETE: begin
                // ram_dout now reflects the address presented during ACCESS.
                state_d = ST_IDLE;
                if (!op_we_q) begin
                    if (owner_q == REQ_A) begin
                        a_rdata_d  = ram_dout;
                        a_rvalid_d = 1'b1;
                    end else begin
                        b_rdata_d  = ram_dout;
                        b_rvalid_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= REQ_A;
            op_we_q    <= 1'b0;
            starve_q   <= '0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_w_q    <= 1'b0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            op_we_q    <= op_we_d;
            starve_q   <= starve_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_w_q    <= ram_w_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign a_gnt    = a_gnt_q;
    assign b_gnt    = b_gnt_q;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign ram_w    = ram_w_q;

endmodule

// File: tb/tb_slave_ram_arbiter.sv
// Directed bench for slave_ram_arbiter with a synchronous RAM model and grant/read-data scoreboards.
module tb_slave_ram_arbiter;
    import slave_ram_arb_pkg::*;

    logic       clk;
    logic       reset;
    logic       a_req, a_we, b_req, b_we;
    logic [4:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic [4:0] ram_addr;
    logic [7:0] ram_din;
    logic       ram_w;
    logic [7:0] ram_dout;
`ifdef SLAVE_RAM_ARB_WPROT_EN
    logic [31:0] wprot_mask;
    logic        a_wprot_hit;
`endif

    slave_ram_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_gnt    (a_gnt),
        .a_rdata  (a_rdata),
        .a_rvalid (a_rvalid),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_gnt    (b_gnt),
        .b_rdata  (b_rdata),
        .b_rvalid (b_rvalid),
`ifdef SLAVE_RAM_ARB_WPROT_EN
        .wprot_mask  (wprot_mask),
        .a_wprot_hit (a_wprot_hit),
`endif
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_w    (ram_w),
        .ram_dout (ram_dout)
    );

    typedef struct {
        logic       who;
        logic       we;
        logic [4:0] addr;
        logic [7:0] din;
        logic       hit;
        int         cyc;
    } gexp_t;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } rexp_t;

    gexp_t      gq[$];
    rexp_t      a_rq[$];
    rexp_t      b_rq[$];
    logic [7:0] shadow [32];
    logic [7:0] mem [32];
    int         cyc = 0;
    int         n_assert = 0;
    int         n_fail = 0;
    int         base;
    gexp_t      g;
    rexp_t      r;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_w) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_grant(input logic who, input logic we, input logic [4:0] addr,
                             input logic [7:0] din, input logic hit, input int at);
        gexp_t e;
        rexp_t rr;
        e.who = who; e.we = we; e.addr = addr; e.din = din; e.hit = hit; e.cyc = at;
        gq.push_back(e);
        if (!we) begin
            rr.data = shadow[addr];
            rr.cyc  = at + 2;
            if (who == REQ_A) a_rq.push_back(rr);
            else              b_rq.push_back(rr);
        end else if (!hit) begin
            shadow[addr] = din;
        end
    endtask

    task automatic do_a(input logic we, input logic [4:0] addr, input logic [7:0] d, input logic hit);
        a_we = we; a_addr = addr; a_wdata = d; a_req = 1'b1;
        exp_grant(REQ_A, we, addr, d, hit, cyc + 1);
        tick();
        a_req = 1'b0;
        repeat (4) tick();
    endtask

    task automatic do_b(input logic we, input logic [4:0] addr, input logic [7:0] d);
        b_we = we; b_addr = addr; b_wdata = d; b_req = 1'b1;
        exp_grant(REQ_B, we, addr, d, 1'b0, cyc + 1);
        tick();
        b_req = 1'b0;
        repeat (4) tick();
    endtask

    // Scoreboard side: every grant and every rvalid must match a queued expectation.
    always @(negedge clk) begin
        if (reset) begin
            if (a_gnt || b_gnt) begin
                check("gnt_onehot", 32'(a_gnt & b_gnt), 32'd0);
                if (gq.size() == 0) begin
                    check("gnt_unexpected", 32'(a_gnt | b_gnt), 32'd0);
                end else begin
                    g = gq.pop_front();
                    check("gnt_owner", 32'(b_gnt), 32'(g.who));
                    check("gnt_cycle", 32'(cyc), 32'(g.cyc));
                    check("gnt_ram_addr", 32'(ram_addr), 32'(g.addr));
                    check("gnt_ram_din", 32'(ram_din), 32'(g.din));
                    check("gnt_ram_w", 32'(ram_w), 32'(g.we & ~g.hit));
`ifdef SLAVE_RAM_ARB_WPROT_EN
                    check("gnt_wprot_hit", 32'(a_wprot_hit), 32'(g.hit));
`endif
                end
            end else begin
                check("ram_w_outside_access", 32'(ram_w), 32'd0);
`ifdef SLAVE_RAM_ARB_WPROT_EN
                check("wprot_hit_outside_access", 32'(a_wprot_hit), 32'd0);
`endif
            end
            if (a_rvalid) begin
                if (a_rq.size() == 0) begin
                    check("a_rvalid_unexpected", 32'(a_rvalid), 32'd0);
                end else begin
                    r = a_rq.pop_front();
                    check("a_rdata", 32'(a_rdata), 32'(r.data));
                    check("a_rvalid_cycle", 32'(cyc), 32'(r.cyc));
                end
            end
            if (b_rvalid) begin
                if (b_rq.size() == 0) begin
                    check("b_rvalid_unexpected", 32'(b_rvalid), 32'd0);
                end else begin
                    r = b_rq.pop_front();
                    check("b_rdata", 32'(b_rdata), 32'(r.data));
                    check("b_rvalid_cycle", 32'(cyc), 32'(r.cyc));
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
`ifdef SLAVE_RAM_ARB_WPROT_EN
        wprot_mask = '0;
`endif

        // Reset held with random inputs: every output stays at zero.
        for (int i = 0; i < 4; i++) begin
            a_req = 1'($urandom); a_we = 1'($urandom); a_addr = 5'($urandom); a_wdata = 8'($urandom);
            b_req = 1'($urandom); b_we = 1'($urandom); b_addr = 5'($urandom); b_wdata = 8'($urandom);
            tick();
        end
        check("rst_a_gnt", 32'(a_gnt), 32'd0);
        check("rst_b_gnt", 32'(b_gnt), 32'd0);
        check("rst_a_rvalid", 32'(a_rvalid), 32'd0);
        check("rst_b_rvalid", 32'(b_rvalid), 32'd0);
        check("rst_ram_w", 32'(ram_w), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_din", 32'(ram_din), 32'd0);
        check("rst_a_rdata", 32'(a_rdata), 32'd0);
        check("rst_b_rdata", 32'(b_rdata), 32'd0);
        a_req = 1'b0; b_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // A write, then B writes another location and reads back A's data.
        do_a(1'b1, 5'h03, 8'hA5, 1'b0);
        do_b(1'b1, 5'h10, 8'h3C);
        do_b(1'b0, 5'h03, 8'h00);
        check("a_rdata_untouched", 32'(a_rdata), 32'd0);

        // Contention: A,A,A,A,B; b_req drop before grant 7 clears the counter.
        a_we = 1'b0; a_addr = 5'h03; a_wdata = 8'h11;
        b_we = 1'b0; b_addr = 5'h10; b_wdata = 8'h22;
        base = cyc;
        for (int j = 0; j < 13; j++) begin
            if (j == 4 || j == 12) exp_grant(REQ_B, 1'b0, 5'h10, 8'h22, 1'b0, base + 1 + 3 * j);
            else                   exp_grant(REQ_A, 1'b0, 5'h03, 8'h11, 1'b0, base + 1 + 3 * j);
        end
        a_req = 1'b1; b_req = 1'b1;
        while (cyc < base + 20) tick();
        b_req = 1'b0;
        while (cyc < base + 23) tick();
        b_req = 1'b1;
        while (cyc < base + 37) tick();
        a_req = 1'b0; b_req = 1'b0;
        repeat (5) tick();

        // B keeps req one cycle past gnt: exactly one grant.
        b_we = 1'b0; b_addr = 5'h03; b_wdata = 8'h44; b_req = 1'b1;
        exp_grant(REQ_B, 1'b0, 5'h03, 8'h44, 1'b0, cyc + 1);
        tick(); tick();
        b_req = 1'b0;
        repeat (5) tick();

        // A keeps req past rvalid: a second grant on the following IDLE edge.
        a_we = 1'b0; a_addr = 5'h10; a_wdata = 8'h55; a_req = 1'b1;
        base = cyc;
        exp_grant(REQ_A, 1'b0, 5'h10, 8'h55, 1'b0, base + 1);
        exp_grant(REQ_A, 1'b0, 5'h10, 8'h55, 1'b0, base + 4);
        while (cyc < base + 4) tick();
        a_req = 1'b0;
        repeat (5) tick();
        check("b_rdata_holds", 32'(b_rdata), 32'h0A5);

        // Async reset in the middle of a write's ACCESS cycle.
        a_we = 1'b1; a_addr = 5'h0A; a_wdata = 8'h77; a_req = 1'b1;
        exp_grant(REQ_A, 1'b1, 5'h0A, 8'h77, 1'b0, cyc + 1);
        tick();
        a_req = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("arst_ram_w", 32'(ram_w), 32'd0);
        check("arst_a_gnt", 32'(a_gnt), 32'd0);
        check("arst_ram_addr", 32'(ram_addr), 32'd0);
        check("arst_ram_din", 32'(ram_din), 32'd0);
        check("arst_a_rdata", 32'(a_rdata), 32'd0);
        check("arst_b_rdata", 32'(b_rdata), 32'd0);
        check("arst_state", 32'(dut.state_q), 32'(ST_IDLE));
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        do_a(1'b0, 5'h03, 8'h00, 1'b0);

`ifdef SLAVE_RAM_ARB_WPROT_EN
        // Protected address: A write completes the handshake but never strobes the RAM.
        wprot_mask = 32'h0000_0080;
        do_a(1'b1, 5'h07, 8'h5A, 1'b1);
        do_b(1'b1, 5'h07, 8'hC3);
        do_a(1'b0, 5'h07, 8'h00, 1'b0);
`endif

        repeat (3) tick();
        check("grant_queue_drained", 32'(gq.size()), 32'd0);
        check("a_read_queue_drained", 32'(a_rq.size()), 32'd0);
        check("b_read_queue_drained", 32'(b_rq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
